// File: rtl/mio_bus_ctrl_pkg.sv
// Shared encodings for the memory/IO bus controller: FSM states, IO map, timeout data.
package mio_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAM_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  localparam logic [3:0]  IO_TAG       = 4'hE;
  localparam logic [1:0]  IO_LED       = 2'd0;
  localparam logic [1:0]  IO_SW        = 2'd1;
  localparam logic [1:0]  IO_CNT       = 2'd2;
  localparam logic [1:0]  IO_STAT      = 2'd3;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mio_io_regs.sv
// Local IO register file: LED latch, free-running cycle counter, sticky bus error.
module mio_io_regs
  import mio_bus_ctrl_pkg::*;
#(
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc,
  input  logic             we,
  input  logic [1:0]       sel,
  input  logic [31:0]      wdata,
  input  logic [LED_W-1:0] sw_in,
  input  logic             set_err,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led_out,
  output logic             bus_err
);

  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_out <= '0;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      cnt <= cnt + 32'd1;
      if (acc && we) begin
        case (sel)
          IO_LED:  led_out <= wdata[LED_W-1:0];
          IO_CNT:  cnt     <= wdata;
          IO_STAT: bus_err <= 1'b0;
          default: ;
        endcase
      end
      if (set_err) bus_err <= 1'b1;
    end
  end

  // Read values are pre-edge, so a counter read returns the count at the accepting edge.
  always_comb begin
    rdata = '0;
    case (sel)
      IO_LED:  rdata = 32'(led_out);
      IO_SW:   rdata = 32'(sw_in);
      IO_CNT:  rdata = cnt;
      IO_STAT: rdata = {31'd0, bus_err};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU data-port controller: decodes each access to RAM (ack-based, watchdog-bounded) or local IO.
module mio_bus_ctrl
  import mio_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16,
  parameter int LED_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_mem_w,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  input  logic [LED_W-1:0]  sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic             accept, is_io, io_acc, wd_expire, set_err;
  logic [31:0]      io_rdata;
  logic             unused_addr;

  // The ready cycle is spent in IDLE; the CPU's still-held request must not start a second access.
  assign accept      = (state == ST_IDLE) && cpu_req && !cpu_ready;
  assign is_io       = (cpu_addr[31:28] == IO_TAG);
  assign io_acc      = accept && is_io;
  assign wd_expire   = (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign set_err     = (state == ST_RAM_WAIT) && !ram_ack && wd_expire;
  assign unused_addr = ^{cpu_addr[27:ADDR_W+2], cpu_addr[1:0]};

  mio_io_regs #(.LED_W(LED_W)) u_io_regs (
    .clk     (clk),
    .reset   (reset),
    .acc     (io_acc),
    .we      (cpu_mem_w),
    .sel     (cpu_addr[3:2]),
    .wdata   (cpu_wdata),
    .sw_in   (sw_in),
    .set_err (set_err),
    .rdata   (io_rdata),
    .led_out (led_out),
    .bus_err (bus_err)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      wd_cnt    <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_io) begin
              cpu_rdata <= cpu_mem_w ? 32'd0 : io_rdata;
              state     <= ST_RESP;
            end else begin
              ram_en    <= 1'b1;
              ram_we    <= cpu_mem_w;
              ram_addr  <= cpu_addr[ADDR_W+1:2];
              ram_wdata <= cpu_wdata;
              wd_cnt    <= '0;
              state     <= ST_RAM_WAIT;
            end
          end
        end
        ST_RAM_WAIT: begin
          if (ram_ack) begin
            cpu_rdata <= ram_we ? 32'd0 : ram_rdata;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            state     <= ST_RESP;
          end else if (wd_expire) begin
            cpu_rdata <= TIMEOUT_DATA;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            state     <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          cpu_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
